// File: rtl/bcd_count_ctrl_pkg.sv
// Shared types and default timing constants for the BCD counter control front-end.
package bcd_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_t;

  localparam int C_DEBOUNCE     = 32'd65536;
  localparam int C_REPEAT_DELAY = 32'd4194304;
  localparam int C_REPEAT_RATE  = 32'd2097152;

endpackage

// File: rtl/bcd_count_ctrl_if.sv
// Board-side bundle: raw buttons and switches in, counter commands and debug state out.
interface bcd_count_ctrl_if;

  logic [1:0] BTN_N;
  logic       SW_REPEAT;
  logic       SW_FREEZE;
  logic       INC;
  logic       CLR;
  logic [1:0] STATE;

  modport master (output BTN_N, SW_REPEAT, SW_FREEZE, input INC, CLR, STATE);
  modport slave  (input BTN_N, SW_REPEAT, SW_FREEZE, output INC, CLR, STATE);

endinterface

// File: rtl/bcd_count_ctrl_btn_debounce.sv
// One push-button: 2-FF synchroniser, press/release debounce FSM, accept pulse on a stable press.
module btn_debounce
  import bcd_ctrl_pkg::*;
#(
  parameter int P_DEBOUNCE = C_DEBOUNCE
) (
  input  logic       CLK1,
  input  logic       RST,
  input  logic       btn_n,
  output logic       accept,
  output btn_state_t state
);

  localparam int CW = (P_DEBOUNCE > 1) ? $clog2(P_DEBOUNCE) : 1;
  localparam logic [CW-1:0] CNT_TERM = CW'(P_DEBOUNCE - 1);

  logic [1:0]    sync_r;
  logic          btn_low_s;
  logic [CW-1:0] cnt_r;
  btn_state_t    state_r;

  // Synchroniser stages idle at 1 so reset looks like a released button.
  always_ff @(posedge CLK1 or posedge RST) begin
    if (RST) begin
      sync_r <= 2'b11;
    end else begin
      sync_r <= {sync_r[0], btn_n};
    end
  end

  assign btn_low_s = ~sync_r[1];

  // Accept is decoded from the transition so the registered INC/CLR land one edge later.
  always_comb begin
    accept = 1'b0;
    if ((state_r == PRESS_WAIT) && btn_low_s && (cnt_r == CNT_TERM)) begin
      accept = 1'b1;
    end else begin
      accept = 1'b0;
    end
  end

  // Debounce FSM; the counter only advances below its terminal value.
  always_ff @(posedge CLK1 or posedge RST) begin
    if (RST) begin
      state_r <= IDLE;
      cnt_r   <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          cnt_r <= '0;
          if (btn_low_s) state_r <= PRESS_WAIT;
        end
        PRESS_WAIT: begin
          if (!btn_low_s) begin
            state_r <= IDLE;
            cnt_r   <= '0;
          end else if (cnt_r == CNT_TERM) begin
            state_r <= PRESSED;
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
        end
        PRESSED: begin
          if (!btn_low_s) begin
            state_r <= RELEASE_WAIT;
            cnt_r   <= '0;
          end
        end
        RELEASE_WAIT: begin
          if (btn_low_s) begin
            state_r <= PRESSED;
          end else if (cnt_r == CNT_TERM) begin
            state_r <= IDLE;
            cnt_r   <= '0;
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= '0;
        end
      endcase
    end
  end

  assign state = state_r;

endmodule

// File: rtl/bcd_count_ctrl.sv
// Button front-end for the BCD counter: debounced INC/CLR commands, auto-repeat and freeze.
module bcd_count_ctrl
  import bcd_ctrl_pkg::*;
#(
  parameter int P_DEBOUNCE     = C_DEBOUNCE,
  parameter int P_REPEAT_DELAY = C_REPEAT_DELAY,
  parameter int P_REPEAT_RATE  = C_REPEAT_RATE
) (
  input logic             CLK1,
  input logic             RST,
  bcd_count_ctrl_if.slave bus
);

  localparam int DW = (P_REPEAT_DELAY > 1) ? $clog2(P_REPEAT_DELAY) : 1;
  localparam int RW = (P_REPEAT_RATE > 1) ? $clog2(P_REPEAT_RATE) : 1;
  localparam logic [DW-1:0] DLY_TERM  = DW'(P_REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RATE_TERM = RW'(P_REPEAT_RATE - 1);

  logic          accept0_s;
  logic          accept1_s;
  btn_state_t    state0_s;
  btn_state_t    state1_s;
  logic          rpt_en_s;
  logic          rpt_fire_s;
  logic          rpt_run_r;
  logic [DW-1:0] dly_cnt_r;
  logic [RW-1:0] rate_cnt_r;
  logic          inc_r;
  logic          clr_r;

  btn_debounce #(.P_DEBOUNCE(P_DEBOUNCE)) u_btn_count (
    .CLK1   (CLK1),
    .RST    (RST),
    .btn_n  (bus.BTN_N[0]),
    .accept (accept0_s),
    .state  (state0_s)
  );

  btn_debounce #(.P_DEBOUNCE(P_DEBOUNCE)) u_btn_clear (
    .CLK1   (CLK1),
    .RST    (RST),
    .btn_n  (bus.BTN_N[1]),
    .accept (accept1_s),
    .state  (state1_s)
  );

  assign rpt_en_s = (state0_s == PRESSED) && bus.SW_REPEAT;

  // Repeat fires once after the initial delay, then on every rate period.
  always_comb begin
    rpt_fire_s = 1'b0;
    if (!rpt_en_s) begin
      rpt_fire_s = 1'b0;
    end else if (!rpt_run_r) begin
      rpt_fire_s = (dly_cnt_r == DLY_TERM);
    end else begin
      rpt_fire_s = (rate_cnt_r == RATE_TERM);
    end
  end

  // Repeat timer: held cleared outside PRESSED or with repeat disabled.
  always_ff @(posedge CLK1 or posedge RST) begin
    if (RST) begin
      rpt_run_r  <= 1'b0;
      dly_cnt_r  <= '0;
      rate_cnt_r <= '0;
    end else if (!rpt_en_s) begin
      rpt_run_r  <= 1'b0;
      dly_cnt_r  <= '0;
      rate_cnt_r <= '0;
    end else if (!rpt_run_r) begin
      if (dly_cnt_r == DLY_TERM) begin
        rpt_run_r  <= 1'b1;
        rate_cnt_r <= '0;
      end else begin
        dly_cnt_r <= dly_cnt_r + 1'b1;
      end
    end else begin
      if (rate_cnt_r == RATE_TERM) begin
        rate_cnt_r <= '0;
      end else begin
        rate_cnt_r <= rate_cnt_r + 1'b1;
      end
    end
  end

  // Command outputs: clear wins over a coincident increment, which is dropped.
  always_ff @(posedge CLK1 or posedge RST) begin
    if (RST) begin
      inc_r <= 1'b0;
      clr_r <= 1'b0;
    end else begin
      clr_r <= accept1_s;
      inc_r <= (accept0_s | rpt_fire_s) & ~bus.SW_FREEZE & ~accept1_s;
    end
  end

  assign bus.INC   = inc_r;
  assign bus.CLR   = clr_r;
  assign bus.STATE = state0_s;

endmodule

// File: tb/tb_bcd_count_ctrl.sv
// Directed bench for bcd_count_ctrl with short debounce/repeat timing.
module tb_bcd_count_ctrl;

  localparam int EXP_LAT = 18;

  logic CLK1 = 1'b0;
  logic RST  = 1'b1;
  int   total = 0;
  int   bad   = 0;

  bcd_count_ctrl_if bif ();

  bcd_count_ctrl #(
    .P_DEBOUNCE     (16),
    .P_REPEAT_DELAY (64),
    .P_REPEAT_RATE  (16)
  ) dut (
    .CLK1 (CLK1),
    .RST  (RST),
    .bus  (bif)
  );

  always #5 CLK1 = ~CLK1;

  task automatic step();
    @(posedge CLK1);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    bif.BTN_N = 2'b11;
    bif.SW_REPEAT = 1'b0;
    bif.SW_FREEZE = 1'b0;
    step();
    step();
    RST = 1'b0;
    for (int n = 0; n < 50; n++) begin
      step();
      total++;
      if (bif.INC !== 1'b0 || bif.CLR !== 1'b0 || bif.STATE !== 2'd0) begin
        bad++;
        $display("FAIL reset_idle cycle %0d: INC=%b CLR=%b STATE=%0d, want 0 0 0", n, bif.INC, bif.CLR, bif.STATE);
      end
    end
  endtask

  task automatic test_single_press();
    int cnt;
    int at;
    for (int p = 0; p < 5; p++) begin
      cnt = 0;
      at = -1;
      for (int n = 0; n < 100; n++) begin
        bif.BTN_N[0] = (n < 40) ? 1'b0 : 1'b1;
        step();
        if (bif.INC === 1'b1) begin
          cnt++;
          at = n;
        end
      end
      total++;
      if (cnt !== 1) begin
        bad++;
        $display("FAIL press_count #%0d: got %0d pulses, want 1", p, cnt);
      end
      total++;
      if (at !== EXP_LAT) begin
        bad++;
        $display("FAIL press_latency #%0d: INC at cycle %0d, want %0d", p, at, EXP_LAT);
      end
    end
    total++;
    if (bif.STATE !== 2'd0) begin
      bad++;
      $display("FAIL press_final_state: STATE=%0d, want 0", bif.STATE);
    end
  endtask

  task automatic test_chatter();
    int lens [14] = '{5, 30, 10, 30, 3, 3, 3, 3, 3, 3, 3, 3, 3, 30};
    int inc_cnt = 0;
    int saw_pressed = 0;
    int saw_wait = 0;
    for (int s = 0; s < 14; s++) begin
      for (int n = 0; n < lens[s]; n++) begin
        bif.BTN_N[0] = (s % 2 == 0) ? 1'b0 : 1'b1;
        step();
        if (bif.INC === 1'b1) inc_cnt++;
        if (bif.STATE === 2'd2) saw_pressed++;
        if (bif.STATE === 2'd1) saw_wait++;
      end
    end
    total++;
    if (inc_cnt !== 0) begin
      bad++;
      $display("FAIL chatter_inc: got %0d pulses, want 0", inc_cnt);
    end
    total++;
    if (saw_pressed !== 0) begin
      bad++;
      $display("FAIL chatter_state: STATE=2 seen %0d cycles, want 0", saw_pressed);
    end
    total++;
    if (saw_wait == 0) begin
      bad++;
      $display("FAIL chatter_wait: STATE=1 seen 0 cycles, want >0");
    end
  endtask

  task automatic test_repeat();
    int pulses [16];
    int np = 0;
    int exp_at;
    bif.SW_REPEAT = 1'b1;
    for (int n = 0; n < 260; n++) begin
      bif.BTN_N[0] = (n < 200) ? 1'b0 : 1'b1;
      step();
      if (bif.INC === 1'b1) begin
        if (np < 16) pulses[np] = n;
        np++;
      end
    end
    bif.SW_REPEAT = 1'b0;
    total++;
    if (np !== 9) begin
      bad++;
      $display("FAIL repeat_count: got %0d pulses, want 9", np);
    end
    for (int k = 0; k < 9 && k < np; k++) begin
      exp_at = (k == 0) ? EXP_LAT : EXP_LAT + 64 + 16 * (k - 1);
      total++;
      if (pulses[k] !== exp_at) begin
        bad++;
        $display("FAIL repeat_pulse[%0d]: at cycle %0d, want %0d", k, pulses[k], exp_at);
      end
    end
  endtask

  task automatic test_repeat_stop();
    int pulses [8];
    int np = 0;
    bif.SW_REPEAT = 1'b1;
    for (int n = 0; n < 160; n++) begin
      bif.BTN_N[0] = (n < 100) ? 1'b0 : 1'b1;
      if (n == 90) bif.SW_REPEAT = 1'b0;
      step();
      if (bif.INC === 1'b1) begin
        if (np < 8) pulses[np] = n;
        np++;
      end
    end
    total++;
    if (np !== 2) begin
      bad++;
      $display("FAIL repeat_stop_count: got %0d pulses, want 2", np);
    end
    total++;
    if (np >= 2 && (pulses[0] !== EXP_LAT || pulses[1] !== EXP_LAT + 64)) begin
      bad++;
      $display("FAIL repeat_stop_times: got %0d,%0d, want %0d,%0d", pulses[0], pulses[1], EXP_LAT, EXP_LAT + 64);
    end
  endtask

  task automatic test_simultaneous();
    int clr_cnt = 0;
    int clr_at = -1;
    int inc_cnt = 0;
    for (int n = 0; n < 100; n++) begin
      bif.BTN_N = (n < 40) ? 2'b00 : 2'b11;
      step();
      if (bif.CLR === 1'b1) begin
        clr_cnt++;
        clr_at = n;
      end
      if (bif.INC === 1'b1) inc_cnt++;
    end
    total++;
    if (clr_cnt !== 1 || clr_at !== EXP_LAT) begin
      bad++;
      $display("FAIL simul_clr: %0d pulses at cycle %0d, want 1 at %0d", clr_cnt, clr_at, EXP_LAT);
    end
    total++;
    if (inc_cnt !== 0) begin
      bad++;
      $display("FAIL simul_inc: got %0d pulses, want 0", inc_cnt);
    end
  endtask

  task automatic test_freeze();
    int inc_cnt = 0;
    logic [1:0] exp_st;
    bif.SW_FREEZE = 1'b1;
    for (int n = 0; n < 100; n++) begin
      bif.BTN_N[0] = (n < 40) ? 1'b0 : 1'b1;
      step();
      if (bif.INC === 1'b1) inc_cnt++;
      exp_st = 2'd0;
      if (n >= 2 && n < 18) exp_st = 2'd1;
      else if (n >= 18 && n < 42) exp_st = 2'd2;
      else if (n >= 42 && n < 58) exp_st = 2'd3;
      total++;
      if (bif.STATE !== exp_st) begin
        bad++;
        $display("FAIL freeze_state cycle %0d: STATE=%0d, want %0d", n, bif.STATE, exp_st);
      end
    end
    bif.SW_FREEZE = 1'b0;
    total++;
    if (inc_cnt !== 0) begin
      bad++;
      $display("FAIL freeze_inc: got %0d pulses, want 0", inc_cnt);
    end
  endtask

  task automatic test_reset_mid_press();
    int early = 0;
    int cnt = 0;
    int at = -1;
    bif.BTN_N[0] = 1'b0;
    for (int n = 0; n < 10; n++) begin
      step();
      if (bif.INC === 1'b1) early++;
    end
    RST = 1'b1;
    #1;
    total++;
    if (bif.STATE !== 2'd0 || bif.INC !== 1'b0) begin
      bad++;
      $display("FAIL midreset_async: STATE=%0d INC=%b, want 0 0", bif.STATE, bif.INC);
    end
    step();
    step();
    RST = 1'b0;
    for (int m = 0; m < 90; m++) begin
      bif.BTN_N[0] = (m < 28) ? 1'b0 : 1'b1;
      step();
      if (bif.INC === 1'b1) begin
        cnt++;
        at = m;
      end
    end
    total++;
    if (early !== 0) begin
      bad++;
      $display("FAIL midreset_early: got %0d pulses before reset, want 0", early);
    end
    total++;
    if (cnt !== 1 || at !== EXP_LAT) begin
      bad++;
      $display("FAIL midreset_after: %0d pulses at cycle %0d, want 1 at %0d", cnt, at, EXP_LAT);
    end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_chatter();
    test_repeat();
    test_repeat_stop();
    test_simultaneous();
    test_freeze();
    test_reset_mid_press();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
